dp_ram_tdp: RTL and testbench

Parametrised true dual-port RAM that supersedes the fixed 18x1024 dual-port RAM. It adds registered (synchronous) reads, a selectable read-during-write mode, deterministic same-address collision handling, and a hardware clear engine that zeroes the whole array after reset or on request. It sits between datapath blocks that need two independent read/write ports on one shared buffer.

---
 rtl/dp_ram_tdp.sv | 124 ++++++++++++
 tb/tb_dp_ram_tdp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_tdp.sv
// Parametrised true dual-port RAM with registered reads, selectable read-during-write
// behaviour, A-priority collision handling and a sweep engine that zeroes the array.
module dp_ram_tdp #(
    parameter int DW       = 18,
    parameter int AW       = 10,
    parameter int RDW_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [AW-1:0] addrA,
    input  logic [DW-1:0] dataA,
    input  logic          weA,
    input  logic [AW-1:0] addrB,
    input  logic [DW-1:0] dataB,
    input  logic          weB,
    output logic [DW-1:0] qA,
    output logic [DW-1:0] qB,
    output logic          ready,
    output logic          coll
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW-1:0] PTR_LAST = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] qa_q, qa_d;
    logic [DW-1:0] qb_q, qb_d;
    logic          coll_q, coll_d;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          run;
    logic          same_addr;
    logic          wr_a_en, wr_b_en, wr_clr_en;
    logic [DW-1:0] rd_a, rd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            qa_q    <= '0;
            qb_q    <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        run       = (state_q == RUN);
        same_addr = (addrA == addrB);
        // Reset itself never disturbs the array, so every write path is gated by rst.
        wr_clr_en = !run && !rst;
        wr_a_en   = run && weA && !rst;
        wr_b_en   = run && weB && !rst && !(weA && same_addr);

        rd_a = mem[addrA];
        rd_b = mem[addrB];
        if (RDW_MODE != 0) begin
            if (weA) begin
                rd_a = dataA;
            end else if (weB && same_addr) begin
                rd_a = dataB;
            end
            if (weA && same_addr) begin
                rd_b = dataA;
            end else if (weB) begin
                rd_b = dataB;
            end
        end

        qa_d   = run ? rd_a : '0;
        qb_d   = run ? rd_b : '0;
        coll_d = run && weA && weB && same_addr;
    end

    always_ff @(posedge clk) begin
        if (wr_clr_en) begin
            mem[ptr_q] <= '0;
        end
        if (wr_b_en) begin
            mem[addrB] <= dataB;
        end
        if (wr_a_en) begin
            mem[addrA] <= dataA;
        end
    end

    assign qA    = qa_q;
    assign qB    = qb_q;
    assign ready = (state_q == RUN);
    assign coll  = coll_q;

endmodule

// File: tb/tb_dp_ram_tdp.sv
// Bench for dp_ram_tdp: one read-first and one write-first instance share stimulus;
// the driver queues expected results and a monitor compares them after each edge.
module tb_dp_ram_tdp;

    localparam int DW = 18;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, clr, weA, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dataA, dataB;
    logic [DW-1:0] qA0, qB0, qA1, qB1;
    logic          ready0, ready1, coll0, coll1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        bit            chk_q;
        logic [DW-1:0] qa0, qb0, qa1, qb1;
        logic          rdy;
        logic          coll;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dp_ram_tdp #(.DW(DW), .AW(AW), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr),
        .addrA(addrA), .dataA(dataA), .weA(weA),
        .addrB(addrB), .dataB(dataB), .weB(weB),
        .qA(qA0), .qB(qB0), .ready(ready0), .coll(coll0)
    );

    dp_ram_tdp #(.DW(DW), .AW(AW), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .addrA(addrA), .dataA(dataA), .weA(weA),
        .addrB(addrB), .dataB(dataB), .weB(weB),
        .qA(qA1), .qB(qB1), .ready(ready1), .coll(coll1)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".ready0"}, DW'(ready0), DW'(e.rdy));
                chk({e.name, ".ready1"}, DW'(ready1), DW'(e.rdy));
                chk({e.name, ".coll0"},  DW'(coll0),  DW'(e.coll));
                chk({e.name, ".coll1"},  DW'(coll1),  DW'(e.coll));
                if (e.chk_q) begin
                    chk({e.name, ".qA0"}, qA0, e.qa0);
                    chk({e.name, ".qB0"}, qB0, e.qb0);
                    chk({e.name, ".qA1"}, qA1, e.qa1);
                    chk({e.name, ".qB1"}, qB1, e.qb1);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic c,
                         input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        @(negedge clk);
        rst = r;  clr = c;
        weA = wa; addrA = aa; dataA = da;
        weB = wb; addrB = ab; dataB = db;
    endtask

    task automatic push(input string nm, input bit cq,
                        input logic [DW-1:0] qa0, input logic [DW-1:0] qb0,
                        input logic [DW-1:0] qa1, input logic [DW-1:0] qb1,
                        input logic rdy, input logic cl);
        exp_t e;
        e.name = nm; e.chk_q = cq;
        e.qa0 = qa0; e.qb0 = qb0; e.qa1 = qa1; e.qb1 = qb1;
        e.rdy = rdy; e.coll = cl;
        sb.push_back(e);
    endtask

    function automatic logic [DW-1:0] old_val(input int a);
        case (a)
            5:       return 18'h3FFFF;
            7:       return 18'h00155;
            9:       return 18'h000AA;
            default: return 18'h0;
        endcase
    endfunction

    initial begin : driver
        rst = 1'b1; clr = 1'b0; weA = 1'b0; weB = 1'b0;
        addrA = '0; addrB = '0; dataA = '0; dataB = '0;

        // Reset followed by a 16-cycle sweep with idle ports.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        push("rst", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 4'(i), 0, 0, 4'(15 - i), 0);
            push("sweep0", 1, 0, 0, 0, 0, (i == 15), 0);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 4'(i), 0, 0, 4'(15 - i), 0);
            push("zero0", 1, 0, 0, 0, 0, 1, 0);
        end

        // Port A write to 5 with same-edge reads of 5 on both ports.
        drive(0, 0, 1, 5, 18'h3FFFF, 0, 5, 0);
        push("wr5", 1, 0, 0, 18'h3FFFF, 18'h3FFFF, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        push("rd5", 1, 0, 18'h3FFFF, 0, 18'h3FFFF, 1, 0);

        // Port B write to 7 observed cross-port on A.
        drive(0, 0, 0, 7, 0, 1, 7, 18'h155);
        push("wr7", 1, 0, 0, 18'h155, 18'h155, 1, 0);
        drive(0, 0, 0, 7, 0, 0, 7, 0);
        push("rd7", 1, 18'h155, 18'h155, 18'h155, 18'h155, 1, 0);

        // Same-address collision: A wins, coll pulses for one cycle.
        drive(0, 0, 1, 9, 18'h0AA, 1, 9, 18'h111);
        push("coll9", 1, 0, 0, 18'h0AA, 18'h0AA, 1, 1);
        drive(0, 0, 0, 9, 0, 0, 9, 0);
        push("rd9", 1, 18'h0AA, 18'h0AA, 18'h0AA, 18'h0AA, 1, 0);

        // Fill every word, then clear in RUN with a read in the clr cycle.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 4'(i), 18'h100 + 18'(i), 0, 4'(i), 0);
            push("fill", 1, old_val(i), old_val(i), 18'h100 + 18'(i), 18'h100 + 18'(i), 1, 0);
        end
        drive(0, 1, 0, 3, 0, 0, 3, 0);
        push("clr", 1, 18'h103, 18'h103, 18'h103, 18'h103, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 4'(i), 18'h3FFFF, 1, 4'(i), 18'h2AAAA);
            push("sweep1", 1, 0, 0, 0, 0, (i == 15), 0);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 4'(i), 0, 0, 4'(15 - i), 0);
            push("zero1", 1, 0, 0, 0, 0, 1, 0);
        end

        // Reset arriving mid-sweep restarts the full 16-cycle clear.
        drive(0, 0, 1, 12, 18'h2A5, 0, 12, 0);
        push("wr12", 1, 0, 0, 18'h2A5, 18'h2A5, 1, 0);
        drive(0, 1, 0, 12, 0, 0, 12, 0);
        push("clr2", 1, 18'h2A5, 18'h2A5, 18'h2A5, 18'h2A5, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 3, 18'h1, 1, 3, 18'h2);
            push("part", 1, 0, 0, 0, 0, 0, 0);
        end
        drive(1, 0, 1, 3, 18'h1, 1, 3, 18'h2);
        push("rst2", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 3, 18'h1, 1, 3, 18'h2);
            push("sweep2", 1, 0, 0, 0, 0, (i == 15), 0);
        end
        drive(0, 0, 0, 12, 0, 0, 3, 0);
        push("rd12", 1, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #5;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
